// File: rtl/fifo_reader_pkg.sv
// Shared constants and helpers for the FIFO read-side drain engine.
// The FIFO read latency is fixed at one cycle, so a single in-flight flag is enough.
package fifo_reader_pkg;

  localparam int DATA_WIDTH_DEF  = 4;
  localparam int CNT_WIDTH_DEF   = 8;
  localparam int FIFO_RD_LATENCY = 1;

  typedef logic [1:0] occ_t;
  localparam occ_t OCC_MAX = 2'd2;

  // Buffered words plus the word still on its way back from the FIFO.
  function automatic logic [2:0] pending(input occ_t occ, input logic inflight);
    return {1'b0, occ} + {2'b00, inflight};
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry circular buffer with 1-bit head/tail pointers.
// The head output is fully registered: no path from i_din to o_head_data.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_din,
  output occ_t                  o_occ,
  output logic [DATA_WIDTH-1:0] o_head_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:1];
  logic [DATA_WIDTH-1:0] r_last;
  logic                  r_head;
  logic                  r_tail;
  occ_t                  r_occ;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset) begin
          r_mem[gi] <= '0;
        end else if (i_push && (r_tail == 1'(gi))) begin
          r_mem[gi] <= i_din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= '0;
      r_last <= '0;
    end else begin
      if (i_push) begin
        r_tail <= ~r_tail;
      end
      if (i_pop) begin
        r_head <= ~r_head;
        r_last <= r_mem[r_head];
      end
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // When drained, keep showing the most recently delivered word.
  assign o_head_data = (r_occ != '0) ? r_mem[r_head] : r_last;
  assign o_occ       = r_occ;

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(i_push && !i_pop && (r_occ == OCC_MAX)));

endmodule

// File: rtl/fifo_reader.sv
// Drains a 1-cycle-latency FIFO read port into a 2-entry buffer and presents words
// over valid/ready at one word per cycle; counts words accepted downstream.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_count;
  occ_t                 w_occ;
  logic                 w_pop;
  logic                 w_rd_en;

  assign w_pop = out_valid & out_ready;

  // A read may be issued whenever its word is guaranteed a free slot on arrival.
  assign w_rd_en = !reset && enable && !fifo_empty &&
                   ((pending(w_occ, r_inflight) < 3'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_pop) begin
        r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  fifo_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_inflight),
    .i_pop       (w_pop),
    .i_din       (fifo_dout),
    .o_occ       (w_occ),
    .o_head_data (out_data)
  );

  assign out_valid  = (w_occ != '0);
  assign fifo_rd_en = w_rd_en;
  assign rd_count   = r_count;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader with a behavioural 1-cycle-latency FIFO.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [3:0] fifo_dout = 4'h0;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [7:0] rd_count;

  int n_pass  = 0;
  int n_total = 0;

  // FIFO model: words appended by load_word, read pointer advanced on rd_en.
  logic [3:0] fifo_mem [0:63];
  int         fifo_len = 0;
  int         rd_ptr   = 0;
  logic       force_empty;

  logic [3:0] got_q [$];
  int         got_cyc [$];
  int         cyc;
  int         rden_cnt;

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || (rd_ptr >= fifo_len);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= fifo_mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  fifo_reader dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .rd_count   (rd_count)
  );

  task automatic load_word(input logic [3:0] w);
    fifo_mem[fifo_len[5:0]] = w;
    fifo_len = fifo_len + 1;
  endtask

  // Caller has already waited #1 into the cycle; record handshake and move on.
  task automatic end_cycle();
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_cyc.push_back(cyc);
    end
    if (fifo_rd_en) rden_cnt++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_cyc.delete();
    cyc      = 0;
    rden_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    end_cycle();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic test_reset();
    for (int i = 1; i <= 15; i++) load_word(4'(i));
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1; force_empty = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en c%0d got %b want 0", c, fifo_rd_en); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid c%0d got %b want 0", c, out_valid); else n_pass++;
      n_total++; if (out_data !== 4'h0) $display("FAIL reset_data c%0d got %h want 0", c, out_data); else n_pass++;
      n_total++; if (rd_count !== 8'd0) $display("FAIL reset_count c%0d got %0d want 0", c, rd_count); else n_pass++;
      end_cycle();
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    int first;
    first = -1;
    reset = 1'b0;
    clear_obs();
    for (int c = 0; c < 30; c++) begin
      #1;
      if (c == 0) begin
        n_total++; if (fifo_rd_en !== 1'b1) $display("FAIL stream_first_rd_en got %b want 1", fifo_rd_en); else n_pass++;
      end
      if (first < 0 && out_valid === 1'b1) first = c;
      end_cycle();
    end
    n_total++; if (first != 2) $display("FAIL stream_latency got %0d want 2", first); else n_pass++;
    n_total++; if (got_q.size() != 15) $display("FAIL stream_words got %0d want 15", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < 15; i++) begin
      n_total++;
      if (got_q[i] !== 4'(i + 1) || got_cyc[i] != i + 2)
        $display("FAIL stream_word%0d got %h@%0d want %h@%0d", i, got_q[i], got_cyc[i], 4'(i + 1), i + 2);
      else n_pass++;
    end
    n_total++; if (rd_count !== 8'd15) $display("FAIL stream_count got %0d want 15", rd_count); else n_pass++;
    $display("test_stream done: %0d words", got_q.size());
  endtask

  task automatic test_backpressure();
    int guard;
    do_reset();
    for (int i = 1; i <= 15; i++) load_word(4'(i));
    enable = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c >= 2) begin
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 4'h1)
          $display("FAIL bp_hold c%0d got v=%b d=%h want v=1 d=1", c, out_valid, out_data);
        else n_pass++;
      end
      if (c == 5) begin
        n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL bp_no_read got %b want 0", fifo_rd_en); else n_pass++;
      end
      end_cycle();
    end
    n_total++; if (rden_cnt != 2) $display("FAIL bp_outstanding got %0d want 2", rden_cnt); else n_pass++;
    out_ready = 1'b1;
    guard = 0;
    while (got_q.size() < 15 && guard < 40) begin
      #1;
      end_cycle();
      guard++;
    end
    repeat (3) begin #1; end_cycle(); end
    n_total++; if (got_q.size() != 15) $display("FAIL bp_words got %0d want 15", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < 15; i++) begin
      n_total++;
      if (got_q[i] !== 4'(i + 1)) $display("FAIL bp_word%0d got %h want %h", i, got_q[i], 4'(i + 1));
      else n_pass++;
    end
    n_total++; if (rd_count !== 8'd15) $display("FAIL bp_count got %0d want 15", rd_count); else n_pass++;
    $display("test_backpressure done: %0d words", got_q.size());
  endtask

  task automatic test_empty_gap();
    do_reset();
    for (int i = 4; i <= 11; i++) load_word(4'(i));
    enable = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      force_empty = (c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) begin
        n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL gap_rd_en c%0d got %b want 0", c, fifo_rd_en); else n_pass++;
      end
      if (c == 5 || c == 6) begin
        n_total++; if (out_valid !== 1'b0) $display("FAIL gap_valid c%0d got %b want 0", c, out_valid); else n_pass++;
      end
      end_cycle();
    end
    force_empty = 1'b0;
    n_total++; if (got_q.size() != 8) $display("FAIL gap_words got %0d want 8", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      n_total++;
      if (got_q[i] !== 4'(i + 4)) $display("FAIL gap_word%0d got %h want %h", i, got_q[i], 4'(i + 4));
      else n_pass++;
    end
    n_total++; if (rd_count !== 8'd8) $display("FAIL gap_count got %0d want 8", rd_count); else n_pass++;
    $display("test_empty_gap done: %0d words", got_q.size());
  endtask

  task automatic test_enable_drop();
    do_reset();
    load_word(4'hC); load_word(4'hD); load_word(4'hE);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      enable = (c == 0);
      #1;
      if (c == 0) begin
        n_total++; if (fifo_rd_en !== 1'b1) $display("FAIL en_first_rd got %b want 1", fifo_rd_en); else n_pass++;
      end
      if (c == 1) begin
        n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL en_drop_rd got %b want 0", fifo_rd_en); else n_pass++;
      end
      if (c == 7) begin
        n_total++; if (out_valid !== 1'b0) $display("FAIL en_settle_valid got %b want 0", out_valid); else n_pass++;
      end
      end_cycle();
    end
    n_total++; if (rden_cnt != 1) $display("FAIL en_reads got %0d want 1", rden_cnt); else n_pass++;
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== 4'hC || got_cyc[0] != 2)
      $display("FAIL en_delivered got n=%0d w=%h@%0d want n=1 w=c@2", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 4'h0, (got_cyc.size() > 0) ? got_cyc[0] : -1);
    else n_pass++;
    n_total++; if (rd_count !== 8'd1) $display("FAIL en_count got %0d want 1", rd_count); else n_pass++;
    $display("test_enable_drop done: %0d words", got_q.size());
  endtask

  task automatic test_reset_midop();
    clear_obs();
    load_word(4'hF);
    enable = 1'b1; out_ready = 1'b0; force_empty = 1'b0;
    for (int c = 0; c < 2; c++) begin #1; end_cycle(); end
    #1;
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 4'hD)
      $display("FAIL mid_pre_reset got v=%b d=%h want v=1 d=d", out_valid, out_data);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL mid_reset_rd_en got %b want 0", fifo_rd_en); else n_pass++;
    end_cycle();
    reset = 1'b0; force_empty = 1'b1; out_ready = 1'b1;
    got_q.delete();
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 4'h0) $display("FAIL mid_data got %h want 0", out_data); else n_pass++;
    n_total++; if (rd_count !== 8'd0) $display("FAIL mid_count got %0d want 0", rd_count); else n_pass++;
    end_cycle();
    for (int c = 0; c < 5; c++) begin #1; end_cycle(); end
    n_total++; if (got_q.size() != 0) $display("FAIL mid_ghost_word got %0d words want 0", got_q.size()); else n_pass++;
    $display("test_reset_midop done");
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; force_empty = 1'b1;
    clear_obs();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_gap();
    test_enable_drop();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
